// File: rtl/map_gamma_ctrl.sv
// Gamma branch-metric RAM controller: one frame written, then streamed back out.
// Optional GAMMA_CTRL_REV_READ_EN: read the frame in descending address order.
module map_gamma_ctrl #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 8,
    parameter int FRAME_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic              rd_ready,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [FRAME_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_TURN,
        S_READ,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]  rd_step;

`ifdef GAMMA_CTRL_REV_READ_EN
    localparam logic [ADDR_W-1:0] RD_FIRST = LAST_ADDR;
    localparam logic [ADDR_W-1:0] RD_LAST  = '0;
    assign rd_step = addr_q - 1'b1;
`else
    localparam logic [ADDR_W-1:0] RD_FIRST = '0;
    localparam logic [ADDR_W-1:0] RD_LAST  = LAST_ADDR;
    assign rd_step = addr_q + 1'b1;
`endif

    // Terminal addresses hold rather than step, so no wrap at DEPTH = 2^ADDR_W.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        frame_cnt_d = frame_cnt_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WRITE;
                    addr_d  = '0;
                end
            end
            S_WRITE: begin
                mem_we = in_valid;
                if (in_valid) begin
                    if (addr_q == LAST_ADDR) state_d = S_TURN;
                    else                     addr_d  = addr_q + 1'b1;
                end
            end
            S_TURN: begin
                addr_d  = RD_FIRST;
                state_d = S_READ;
            end
            S_READ: begin
                mem_re = rd_ready;
                if (rd_ready) begin
                    if (addr_q == RD_LAST) state_d = S_DONE;
                    else                   addr_d  = rd_step;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                frame_cnt_d = frame_cnt_q + 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_valid_d = mem_re;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            frame_cnt_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            frame_cnt_q <= frame_cnt_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign mem_addr  = addr_q;
    assign rd_valid  = rd_valid_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_map_gamma_ctrl.sv
// Bench for map_gamma_ctrl: schedules of writes/reads built from the stall pattern.
// Three instances: DEPTH=8, DEPTH=8 with FRAME_W=2, and DEPTH=256.
module tb_map_gamma_ctrl;

    localparam int D = 8;
`ifdef GAMMA_CTRL_REV_READ_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, in_valid, rd_ready;
    logic rst2, start2, iv2, rr2;

    logic       we_a, re_a, rv_a, busy_a, done_a;
    logic [7:0] addr_a, fc_a;
    logic       we_b, re_b, rv_b, busy_b, done_b;
    logic [7:0] addr_b;
    logic [1:0] fc_b;
    logic       we_c, re_c, rv_c, busy_c, done_c;
    logic [7:0] addr_c, fc_c;

    int checks = 0;
    int errors = 0;
    int nfr = 0;

    map_gamma_ctrl #(.DEPTH(D), .ADDR_W(8), .FRAME_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .rd_ready(rd_ready), .mem_we(we_a), .mem_re(re_a),
        .mem_addr(addr_a), .rd_valid(rv_a), .busy(busy_a),
        .done(done_a), .frame_cnt(fc_a)
    );

    map_gamma_ctrl #(.DEPTH(D), .ADDR_W(8), .FRAME_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .rd_ready(rd_ready), .mem_we(we_b), .mem_re(re_b),
        .mem_addr(addr_b), .rd_valid(rv_b), .busy(busy_b),
        .done(done_b), .frame_cnt(fc_b)
    );

    map_gamma_ctrl #(.DEPTH(256), .ADDR_W(8), .FRAME_W(8)) dut_c (
        .clk(clk), .rst(rst2), .start(start2), .in_valid(iv2),
        .rd_ready(rr2), .mem_we(we_c), .mem_re(re_c),
        .mem_addr(addr_c), .rd_valid(rv_c), .busy(busy_c),
        .done(done_c), .frame_cnt(fc_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rd_addr(input int k, input int depth);
        return REV ? depth - 1 - k : k;
    endfunction

    task automatic check_idle(input string tag, input int ea, input int efc);
        chk({tag, "_we"}, we_a, 0);
        chk({tag, "_re"}, re_a, 0);
        chk({tag, "_rv"}, rv_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_addr"}, addr_a, ea);
        chk({tag, "_fc"}, fc_a, efc % 256);
        chk({tag, "_busy_b"}, busy_b, 0);
        chk({tag, "_fc_b"}, fc_b, efc % 4);
    endtask

    // mode 0: full rate, 1: directed stalls, 2: random stalls.
    // abort_k >= 0 asserts rst during the cycle of read number abort_k.
    task automatic run_frame(input int mode, input int abort_k);
        bit ivs[128];
        bit rrs[128];
        int wc[D];
        int rc[D];
        int c, dn, last, st;
        bit ab;
        for (int i = 0; i < 128; i++) begin
            ivs[i] = 1'($urandom);
            rrs[i] = 1'($urandom);
        end
        c = 1;
        for (int k = 0; k < D; k++) begin
            st = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 2);
            for (int s = 0; s < st; s++) begin
                ivs[c] = 1'b0;
                c++;
            end
            ivs[c] = 1'b1;
            wc[k] = c;
            c++;
        end
        c++;
        for (int k = 0; k < D; k++) begin
            st = (mode == 0) ? 0 : (mode == 1) ? ((k == 4) ? 3 : 0)
                                               : $urandom_range(0, 3);
            for (int s = 0; s < st; s++) begin
                rrs[c] = 1'b0;
                c++;
            end
            rrs[c] = 1'b1;
            rc[k] = c;
            c++;
        end
        dn = c;
        ab = (abort_k >= 0);
        last = ab ? rc[abort_k] + 1 : dn + 1;
        for (int cyc = 0; cyc <= last; cyc++) begin
            bit e_we, e_re, e_rv;
            int e_wa, e_ra, e_fc;
            start    = (cyc == 0) || (cyc == wc[2]) || (cyc == dn);
            in_valid = ivs[cyc];
            rd_ready = rrs[cyc];
            rst      = ab && (cyc == rc[abort_k]);
            @(negedge clk);
            if (ab && cyc == last) begin
                check_idle("abort", 0, 0);
            end else begin
                e_we = 0; e_re = 0; e_rv = 0; e_wa = 0; e_ra = 0;
                for (int k = 0; k < D; k++) begin
                    if (wc[k] == cyc) begin
                        e_we = 1;
                        e_wa = k;
                    end
                    if (rc[k] == cyc) begin
                        e_re = 1;
                        e_ra = rd_addr(k, D);
                    end
                    if (rc[k] == cyc - 1) e_rv = 1;
                end
                e_fc = (cyc > dn) ? nfr + 1 : nfr;
                chk("we", we_a, e_we);
                chk("re", re_a, e_re);
                chk("rd_valid", rv_a, e_rv);
                chk("busy", busy_a, (cyc >= 1 && cyc <= dn));
                chk("done", done_a, (cyc == dn));
                chk("frame_cnt", fc_a, e_fc % 256);
                chk("frame_cnt_w2", fc_b, e_fc % 4);
                chk("done_b", done_b, (cyc == dn));
                if (e_we) chk("waddr", addr_a, e_wa);
                if (e_re) chk("raddr", addr_a, e_ra);
                if (cyc >= dn) chk("hold_addr", addr_a, rd_addr(D - 1, D));
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        start = 1'b0;
        nfr = ab ? 0 : nfr + 1;
    endtask

    initial begin
        int wn, rn, dcyc, lastw;
        rst = 1; start = 0; in_valid = 0; rd_ready = 0;
        rst2 = 1; start2 = 0; iv2 = 0; rr2 = 0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("in_rst", 0, 0);
        rst = 0;
        rst2 = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_idle("idle", 0, 0);
        end

        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(2, 3);
        for (int f = 0; f < 5; f++) run_frame(2, -1);

        wn = 0; rn = 0; dcyc = -1; lastw = -1;
        start2 = 1; iv2 = 1; rr2 = 1;
        for (int cyc = 0; cyc <= 520; cyc++) begin
            @(negedge clk);
            if (we_c) begin
                chk("w256_addr", addr_c, wn);
                lastw = int'(addr_c);
                wn++;
            end
            if (re_c) begin
                chk("r256_addr", addr_c, rd_addr(rn, 256));
                rn++;
            end
            if (done_c) dcyc = cyc;
            @(posedge clk);
            #1;
            start2 = 0;
        end
        chk("w256_count", wn, 256);
        chk("r256_count", rn, 256);
        chk("w256_last", lastw, 255);
        chk("d256_cycle", dcyc, 514);
        chk("fc256", fc_c, 1);
        chk("busy256", busy_c, 0);
        chk("addr256_hold", addr_c, rd_addr(255, 256));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
